// File: rtl/sntc_ldpc_encode_ctrl.sv
// Sequencing controller for the NR LDPC encoder and syndrome checker: message in, codeword + pass/fail out.
// Optional macro SNTC_ENC_RETRY_EN: one re-check of a failing syndrome before reporting the error.
module sntc_ldpc_encode_ctrl #(
    parameter int NN      = 208,
    parameter int MM      = 168,
    parameter int CHK_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [NN-MM-1:0]   msg_data,
    output logic [NN-MM-1:0]   enc_msg,
    input  logic [NN-1:0]      enc_cword,
    input  logic               enc_valid_cword,
    output logic               cw_valid,
    input  logic               cw_ready,
    output logic [NN-1:0]      cw_data,
    output logic               cw_err,
    output logic               busy,
    output logic [CNT_W-1:0]   enc_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int K = NN - MM;
    localparam logic [3:0]       WCNT_LOAD = 4'(CHK_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [3:0]       wcnt_r, wcnt_nxt_s;
    logic [K-1:0]     enc_msg_r, enc_msg_nxt_s;
    logic [NN-1:0]    cw_data_r, cw_data_nxt_s;
    logic             cw_err_r, cw_err_nxt_s;
    logic             cw_valid_r;
    logic             busy_r;
    logic [CNT_W-1:0] enc_cnt_r, enc_cnt_nxt_s;
    logic [CNT_W-1:0] err_cnt_r, err_cnt_nxt_s;
    logic             msg_ready_s;
`ifdef SNTC_ENC_RETRY_EN
    logic             retried_r, retried_nxt_s;
`endif

    // Next-state, handshake and counter update logic.
    always_comb begin
        state_nxt_s   = state_r;
        wcnt_nxt_s    = wcnt_r;
        enc_msg_nxt_s = enc_msg_r;
        cw_data_nxt_s = cw_data_r;
        cw_err_nxt_s  = cw_err_r;
        enc_cnt_nxt_s = enc_cnt_r;
        err_cnt_nxt_s = err_cnt_r;
        msg_ready_s   = 1'b0;
`ifdef SNTC_ENC_RETRY_EN
        retried_nxt_s = retried_r;
`endif
        case (state_r)
            IDLE: begin
                msg_ready_s = 1'b1;
                if (msg_valid) begin
                    enc_msg_nxt_s = msg_data;
                    wcnt_nxt_s    = WCNT_LOAD;
`ifdef SNTC_ENC_RETRY_EN
                    retried_nxt_s = 1'b0;
`endif
                    state_nxt_s   = WAIT;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            WAIT: begin
                if (wcnt_r != 4'd0) begin
                    wcnt_nxt_s = wcnt_r - 4'd1;
                end else begin
`ifdef SNTC_ENC_RETRY_EN
                    // A first syndrome failure earns one more full check interval.
                    if (!enc_valid_cword && !retried_r) begin
                        retried_nxt_s = 1'b1;
                        wcnt_nxt_s    = WCNT_LOAD;
                    end else begin
                        cw_data_nxt_s = enc_cword;
                        cw_err_nxt_s  = ~enc_valid_cword;
                        state_nxt_s   = OUT;
                    end
`else
                    cw_data_nxt_s = enc_cword;
                    cw_err_nxt_s  = ~enc_valid_cword;
                    state_nxt_s   = OUT;
`endif
                end
            end
            OUT: begin
                msg_ready_s = cw_ready;
                if (cw_ready) begin
                    if (enc_cnt_r != CNT_MAX) begin
                        enc_cnt_nxt_s = enc_cnt_r + CNT_ONE;
                    end else begin
                        enc_cnt_nxt_s = enc_cnt_r;
                    end
                    if (cw_err_r && (err_cnt_r != CNT_MAX)) begin
                        err_cnt_nxt_s = err_cnt_r + CNT_ONE;
                    end else begin
                        err_cnt_nxt_s = err_cnt_r;
                    end
                    // Accepting the next message on the delivery edge keeps the input side bubble-free.
                    if (msg_valid) begin
                        enc_msg_nxt_s = msg_data;
                        wcnt_nxt_s    = WCNT_LOAD;
`ifdef SNTC_ENC_RETRY_EN
                        retried_nxt_s = 1'b0;
`endif
                        state_nxt_s   = WAIT;
                    end else begin
                        state_nxt_s   = IDLE;
                    end
                end else begin
                    state_nxt_s = OUT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; clr aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r    <= IDLE;
            wcnt_r     <= 4'd0;
            enc_msg_r  <= {K{1'b0}};
            cw_data_r  <= {NN{1'b0}};
            cw_err_r   <= 1'b0;
            cw_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            enc_cnt_r  <= {CNT_W{1'b0}};
            err_cnt_r  <= {CNT_W{1'b0}};
`ifdef SNTC_ENC_RETRY_EN
            retried_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            wcnt_r     <= wcnt_nxt_s;
            enc_msg_r  <= enc_msg_nxt_s;
            cw_data_r  <= cw_data_nxt_s;
            cw_err_r   <= cw_err_nxt_s;
            cw_valid_r <= (state_nxt_s == OUT);
            busy_r     <= (state_nxt_s != IDLE);
            enc_cnt_r  <= enc_cnt_nxt_s;
            err_cnt_r  <= err_cnt_nxt_s;
`ifdef SNTC_ENC_RETRY_EN
            retried_r  <= retried_nxt_s;
`endif
        end
    end

    assign msg_ready = msg_ready_s;
    assign enc_msg   = enc_msg_r;
    assign cw_valid  = cw_valid_r;
    assign cw_data   = cw_data_r;
    assign cw_err    = cw_err_r;
    assign busy      = busy_r;
    assign enc_cnt   = enc_cnt_r;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_sntc_ldpc_encode_ctrl.sv
// Scoreboard bench for sntc_ldpc_encode_ctrl with a linear encoder model and a one-stage syndrome checker.
// Counter width is reduced to 6 bits so saturation is reachable in a short run.
module tb_sntc_ldpc_encode_ctrl;

    localparam int NN       = 208;
    localparam int MM       = 168;
    localparam int K        = NN - MM;
    localparam int CHK_LAT  = 1;
    localparam int TB_CNT_W = 6;
`ifdef SNTC_ENC_RETRY_EN
    localparam int FAIL_LAT = 2 * (CHK_LAT + 1) + 1;
`else
    localparam int FAIL_LAT = CHK_LAT + 2;
`endif

    typedef struct packed {
        logic [K-1:0] msg;
        logic         err;
    } exp_t;

    logic                clk = 1'b0;
    logic                clr, msg_valid, msg_ready, enc_valid_cword;
    logic                cw_valid, cw_ready, cw_err, busy;
    logic [K-1:0]        msg_data, enc_msg;
    logic [NN-1:0]       enc_cword, cw_data;
    logic [TB_CNT_W-1:0] enc_cnt, err_cnt;

    logic                force_bad;
    logic                chk_r;
    logic                exp_err;
    logic                mon_en = 1'b0;
    logic                rec_en = 1'b0;
    logic [TB_CNT_W-1:0] m_enc = '0;
    logic [TB_CNT_W-1:0] m_err = '0;
    exp_t                exp_q[$];
    int                  deliv_q[$];
    int                  cyc = 0;
    int                  checks = 0;
    int                  errors = 0;
    logic [K-1:0]        stim [0:79];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Linear systematic code: zero message gives the zero codeword, low 40 bits carry the message.
    function automatic logic [NN-1:0] enc_model(input logic [K-1:0] m);
        return {m[7:0], m, m, m, m, m};
    endfunction

    assign enc_cword       = enc_model(enc_msg);
    assign enc_valid_cword = chk_r;
    always @(posedge clk) chk_r <= ~force_bad;

    sntc_ldpc_encode_ctrl #(.NN(NN), .MM(MM), .CHK_LAT(CHK_LAT), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .clr(clr), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
        .enc_msg(enc_msg), .enc_cword(enc_cword), .enc_valid_cword(enc_valid_cword),
        .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_err(cw_err),
        .busy(busy), .enc_cnt(enc_cnt), .err_cnt(err_cnt)
    );

    // Monitor: samples between edges, predicts what the next rising edge transfers.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                checks++;
                if (enc_cnt !== m_enc || err_cnt !== m_err) begin
                    errors++;
                    $display("FAIL counters enc_cnt=%h err_cnt=%h expected %h %h", enc_cnt, err_cnt, m_enc, m_err);
                end
                if (clr) begin
                    exp_q.delete();
                    m_enc = '0;
                    m_err = '0;
                end else begin
                    if (cw_valid && cw_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_cw got %h expected no codeword", cw_data);
                        end else begin
                            e = exp_q.pop_front();
                            if (cw_data !== enc_model(e.msg) || cw_err !== e.err) begin
                                errors++;
                                $display("FAIL cw_data/err got %h/%b expected %h/%b", cw_data, cw_err, enc_model(e.msg), e.err);
                            end
                            if (m_enc != '1) m_enc = m_enc + 1'b1;
                            if (e.err && m_err != '1) m_err = m_err + 1'b1;
                            if (rec_en) deliv_q.push_back(cyc);
                        end
                    end
                    if (msg_valid && msg_ready) begin
                        e.msg = msg_data;
                        e.err = exp_err;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired expected finish");
        $fatal(1);
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic wait_cw(input int lim, output int lat);
        lat = 0;
        do begin
            tick;
            #3;
            lat++;
        end while (!cw_valid && lat < lim);
    endtask

    task automatic send_one(input logic [K-1:0] d);
        tick;
        msg_valid = 1'b1;
        msg_data  = d;
    endtask

    task automatic accept_cw;
        tick;
        msg_valid = 1'b0;
        cw_ready  = 1'b1;
        tick;
        cw_ready  = 1'b0;
    endtask

    task automatic do_clr;
        tick;
        clr = 1'b1;
        msg_valid = 1'b0;
        cw_ready = 1'b0;
        tick;
        clr = 1'b0;
    endtask

    task automatic run_stream(input int n, input int budget);
        int sent;
        sent = 0;
        deliv_q.delete();
        rec_en = 1'b1;
        for (int c = 0; c < budget && deliv_q.size() < n; c++) begin
            tick;
            cw_ready = 1'b1;
            if (sent < n) begin
                msg_valid = 1'b1;
                msg_data  = stim[sent];
            end else begin
                msg_valid = 1'b0;
            end
            #1;
            if (msg_valid && msg_ready) sent++;
        end
        tick;
        msg_valid = 1'b0;
        cw_ready  = 1'b0;
        rec_en    = 1'b0;
    endtask

    task automatic test_reset;
        clr = 1'b1; msg_valid = 1'b0; msg_data = '0; cw_ready = 1'b0; force_bad = 1'b0; exp_err = 1'b0;
        repeat (3) tick;
        #3;
        checks++;
        if ({cw_valid, busy, cw_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b expected 000", {cw_valid, busy, cw_err});
        end
        checks++;
        if (enc_cnt !== 6'd0 || err_cnt !== 6'd0) begin
            errors++; $display("FAIL reset_cnt got %h %h expected 0 0", enc_cnt, err_cnt);
        end
        checks++;
        if (enc_msg !== {K{1'b0}} || cw_data !== {NN{1'b0}}) begin
            errors++; $display("FAIL reset_data got %h %h expected 0", enc_msg, cw_data);
        end
        tick;
        clr = 1'b0;
        mon_en = 1'b1;
        #3;
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b expected 1", msg_ready);
        end
    endtask

    task automatic test_first;
        exp_err = 1'b0;
        send_one({K{1'b0}});
        tick;
        msg_valid = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b1 || cw_valid !== 1'b0) begin
            errors++; $display("FAIL first_k busy/cw_valid got %b%b expected 10", busy, cw_valid);
        end
        tick;
        #3;
        checks++;
        if (cw_valid !== 1'b0) begin
            errors++; $display("FAIL first_k1 cw_valid got %b expected 0", cw_valid);
        end
        tick;
        cw_ready = 1'b1;
        #3;
        checks++;
        if (cw_valid !== 1'b1 || cw_data !== {NN{1'b0}} || cw_err !== 1'b0) begin
            errors++; $display("FAIL first_k2 got v=%b d=%h e=%b expected 1/0/0", cw_valid, cw_data, cw_err);
        end
        tick;
        cw_ready = 1'b0;
        #3;
        checks++;
        if (enc_cnt !== 6'd1 || err_cnt !== 6'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL first_cnt got %h %h busy=%b expected 1 0 0", enc_cnt, err_cnt, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] r;
        do_clr;
        exp_err = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r = {$urandom(), $urandom()};
            stim[i] = r[K-1:0];
        end
        run_stream(5, 40);
        #3;
        checks++;
        if (deliv_q.size() != 5) begin
            errors++; $display("FAIL b2b_count got %0d expected 5", deliv_q.size());
        end
        for (int i = 1; i < deliv_q.size(); i++) begin
            checks++;
            if (deliv_q[i] - deliv_q[i-1] != CHK_LAT + 2) begin
                errors++; $display("FAIL b2b_gap got %0d expected %0d", deliv_q[i] - deliv_q[i-1], CHK_LAT + 2);
            end
        end
        checks++;
        if (enc_cnt !== 6'd5) begin
            errors++; $display("FAIL b2b_enc_cnt got %h expected 5", enc_cnt);
        end
    endtask

    task automatic test_stall;
        int lat;
        logic [K-1:0] a, b;
        a = 40'hA5_1234_5678;
        b = 40'h3C_0F0F_F0F0;
        exp_err = 1'b0;
        send_one(a);
        tick;
        msg_valid = 1'b0;
        wait_cw(10, lat);
        checks++;
        if (cw_valid !== 1'b1) begin
            errors++; $display("FAIL stall_wait cw_valid got %b expected 1", cw_valid);
        end
        for (int i = 0; i < 10; i++) begin
            tick;
            #3;
            checks++;
            if (cw_valid !== 1'b1 || cw_data !== enc_model(a) || cw_err !== 1'b0 || msg_ready !== 1'b0 || enc_msg !== a) begin
                errors++; $display("FAIL stall_hold cyc %0d v=%b e=%b rdy=%b d=%h expected 1/0/0 %h", i, cw_valid, cw_err, msg_ready, cw_data, enc_model(a));
            end
        end
        tick;
        msg_valid = 1'b1;
        msg_data  = b;
        cw_ready  = 1'b1;
        #1;
        checks++;
        if (msg_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release msg_ready got %b expected 1", msg_ready);
        end
        tick;
        msg_valid = 1'b0;
        cw_ready  = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b1 || cw_valid !== 1'b0 || enc_msg !== b) begin
            errors++; $display("FAIL stall_next busy=%b v=%b enc_msg=%h expected 1/0/%h", busy, cw_valid, enc_msg, b);
        end
        wait_cw(10, lat);
        accept_cw;
    endtask

    task automatic test_error;
        int lat;
        do_clr;
        force_bad = 1'b1;
        exp_err   = 1'b1;
        send_one(40'h11_2233_4455);
        tick;
        msg_valid = 1'b0;
        #3;
        lat = 1;
        while (!cw_valid && lat < 12) begin
            tick;
            #3;
            lat++;
        end
        checks++;
        if (lat != FAIL_LAT || cw_err !== 1'b1) begin
            errors++; $display("FAIL err_latency got %0d err=%b expected %0d err=1", lat, cw_err, FAIL_LAT);
        end
        accept_cw;
        force_bad = 1'b0;
        #3;
        checks++;
        if (enc_cnt !== 6'd1 || err_cnt !== 6'd1) begin
            errors++; $display("FAIL err_cnt got %h %h expected 1 1", enc_cnt, err_cnt);
        end
`ifdef SNTC_ENC_RETRY_EN
        force_bad = 1'b1;
        exp_err   = 1'b0;
        send_one(40'h66_7788_99AA);
        tick;
        msg_valid = 1'b0;
        tick;
        tick;
        force_bad = 1'b0;
        wait_cw(10, lat);
        checks++;
        if (cw_valid !== 1'b1 || cw_err !== 1'b0) begin
            errors++; $display("FAIL retry_recover got v=%b err=%b expected 1/0", cw_valid, cw_err);
        end
        accept_cw;
`endif
    endtask

    task automatic test_clr;
        int lat;
        logic seen;
        exp_err = 1'b0;
        send_one(40'hDE_AD00_BEEF);
        tick;
        msg_valid = 1'b0;
        clr = 1'b1;
        tick;
        clr = 1'b0;
        #3;
        checks++;
        if (cw_valid !== 1'b0 || busy !== 1'b0 || enc_cnt !== 6'd0 || err_cnt !== 6'd0 || msg_ready !== 1'b1) begin
            errors++; $display("FAIL clr_wait v=%b busy=%b cnt=%h/%h rdy=%b expected 0/0/0/0/1", cw_valid, busy, enc_cnt, err_cnt, msg_ready);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            #3;
            seen = seen | cw_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL clr_wait_drop cw_valid seen %b expected 0", seen);
        end
        send_one(40'h01_0203_0405);
        tick;
        msg_valid = 1'b0;
        wait_cw(10, lat);
        accept_cw;
        send_one(40'hCA_FE00_1234);
        tick;
        msg_valid = 1'b0;
        wait_cw(10, lat);
        tick;
        clr = 1'b1;
        cw_ready = 1'b1;
        msg_valid = 1'b1;
        msg_data = 40'h77_7777_7777;
        tick;
        clr = 1'b0;
        cw_ready = 1'b0;
        msg_valid = 1'b0;
        #3;
        checks++;
        if (cw_valid !== 1'b0 || busy !== 1'b0 || enc_cnt !== 6'd0 || err_cnt !== 6'd0) begin
            errors++; $display("FAIL clr_out v=%b busy=%b cnt=%h/%h expected 0/0/0/0", cw_valid, busy, enc_cnt, err_cnt);
        end
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            #3;
            seen = seen | cw_valid;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL clr_out_drop cw_valid seen %b expected 0", seen);
        end
    endtask

    task automatic test_saturation;
        do_clr;
        force_bad = 1'b1;
        exp_err   = 1'b1;
        for (int i = 0; i < 65; i++) stim[i] = K'(i * 7 + 3);
        run_stream(65, 1000);
        force_bad = 1'b0;
        #3;
        checks++;
        if (deliv_q.size() != 65) begin
            errors++; $display("FAIL sat_count got %0d expected 65", deliv_q.size());
        end
        checks++;
        if (enc_cnt !== 6'h3F || err_cnt !== 6'h3F) begin
            errors++; $display("FAIL sat_cnt got %h %h expected 3f 3f", enc_cnt, err_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_first;
        test_back_to_back;
        test_stall;
        test_error;
        test_clr;
        test_saturation;
        repeat (2) tick;
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL leftover_msgs got %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sntc_ldpc_encode_ctrl.md
# sntc_ldpc_encode_ctrl

Sequencing controller for the NR LDPC encoder (NN=208, MM=168, K=40) and its syndrome checker. Accepts 40-bit messages over a valid/ready handshake, drives the encoder input, waits out the syndrome-check latency, and presents the 208-bit codeword with a pass/fail flag on an output valid/ready handshake. Also keeps saturating delivered and failed codeword counters for status readout.

## Interface
- `NN`, 208, codeword length.
- `MM`, 168, parity/check count; message width K = NN-MM = 40.
- `CHK_LAT`, 1, register stages between `enc_msg` and `enc_valid_cword` (0 allowed; legal range 0..15).
- `CNT_W`, 16, status counter width.
- `clk`  in  1  clock.
- `clr`  in  1  reset, synchronous, active-high.
- `msg_valid`  in  1  message offered.
- `msg_ready`  out  1  controller accepts message.
- `msg_data`  in  NN-MM  message bits.
- `enc_msg`  out  NN-MM  registered message driven to the encoder input.
- `enc_cword`  in  NN  encoder codeword output.
- `enc_valid_cword`  in  1  syndrome-zero indication from the checker.
- `cw_valid`  out  1  codeword available.
- `cw_ready`  in  1  downstream accepts codeword.
- `cw_data`  out  NN  captured codeword.
- `cw_err`  out  1  captured codeword failed syndrome check; qualified by `cw_valid`.
- `busy`  out  1  state != IDLE.
- `enc_cnt`  out  CNT_W  codewords delivered, saturating.
- `err_cnt`  out  CNT_W  codewords delivered with `cw_err`=1, saturating.

## Operation
- States: IDLE, WAIT, OUT.
- IDLE: `msg_ready`=1. On `msg_valid`: `enc_msg`<=`msg_data`, `wcnt`<=CHK_LAT, `retried`<=0, go WAIT.
- WAIT: `msg_ready`=0; `enc_msg` held. While `wcnt`!=0, decrement. At `wcnt`==0: capture `cw_data`<=`enc_cword` and `cw_err`<=~`enc_valid_cword`, go OUT. The retry path is described under Configuration.
- OUT: `cw_valid`=1; `cw_data`, `cw_err` and `enc_msg` are held stable until the handshake completes. On `cw_ready`: `enc_cnt`++ (saturating at all-ones), and `err_cnt`++ (saturating) if `cw_err`.
  - If `msg_valid` is also high: load the new message and go WAIT.
  - Otherwise: go IDLE.
- `msg_ready` = (state==IDLE) | (state==OUT & `cw_ready`). This allows back-to-back operation with no bubble on the input side.
- A message is never dropped or duplicated. A codeword is never overwritten before it is accepted.
- Simultaneous `clr` with any handshake: `clr` wins. Neither transfer counts.

## Timing
- Reset (`clr`=1 at a rising edge) sets state IDLE and clears `enc_msg`, `cw_data`, `cw_err`, `cw_valid`, `busy`, `enc_cnt`, `err_cnt`, `wcnt` and `retried` to 0.
- `clr` mid-operation aborts the operation immediately. The in-flight codeword is lost and no counters change.
- WAIT lasts CHK_LAT+1 cycles, so `enc_valid_cword` is sampled exactly CHK_LAT+1 edges after `enc_msg` updates.
- Message accepted at edge k → `cw_valid` high from edge k+CHK_LAT+1 (CHK_LAT=1: edge k+2).
- Sustained throughput: one codeword per CHK_LAT+2 cycles with `cw_ready` held high.
- All outputs are registered except `msg_ready`, which is combinational from state and `cw_ready`.

## Configuration
- `SNTC_ENC_RETRY_EN` defined:
  - At the WAIT sample, if `enc_valid_cword`=0 and `retried`=0: set `retried`<=1, reload `wcnt`<=CHK_LAT, stay in WAIT. `enc_msg` is unchanged.
  - A second failure goes to OUT with `cw_err`=1.
  - Worst-case latency is 2·(CHK_LAT+1) edges.
- Not defined: no retry. `retried` is not implemented. The first failure goes directly to OUT with `cw_err`=1.

## Test plan
- Reset, then `msg_data`=40'h0: after edge k+2, `cw_valid`=1, `cw_data`=208'h0, `cw_err`=0. Accept it → `enc_cnt`=1, `err_cnt`=0.
- Five back-to-back random messages with `msg_valid` and `cw_ready` held high: a new `cw_valid` every 3 cycles. Each `cw_data[39:0]` equals its message, the syndrome model reports 0, and `enc_cnt`=5.
- `cw_ready` low for 10 cycles in OUT: `cw_data` and `cw_err` stable and `msg_ready`=0 throughout. Raising `cw_ready` with `msg_valid`=1 accepts both on the same edge.
- Force `enc_valid_cword`=0:
  - Without the macro: `cw_err`=1 at k+2 and `err_cnt`=1.
  - With the macro: `busy` is extended, `cw_valid` rises at k+4 with `cw_err`=1.
  - With the macro and the force released after the first sample: `cw_err`=0.
- Assert `clr` during WAIT and, separately, during OUT: the next edge gives state IDLE, `cw_valid`=0 and counters 0, and the aborted message is never delivered.
- Preload the counters to 16'hFFFE and deliver 3 failing codewords: `enc_cnt` and `err_cnt` both saturate at 16'hFFFF.
